fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction fetch stage for the 5-stage RV64 pipeline. Sits between the PC/instruction SRAM (sram_BW32, 1-cycle registered read) and the IF/ID pipeline register.
- Owns the fetch PC and issues one read per cycle.
- Buffers returned {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Flushes on branch/jump redirect from EX.

Parameters:
- DATA_W, 64, PC width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  main clock
- arst  in  1  asynchronous reset, active-high
- enable  in  1  fetch allowed; low = no new requests, FIFO holds
- redirect_valid  in  1  taken branch/jump from EX, one-cycle pulse
- redirect_pc  in  DATA_W  redirect target
- imem_addr  out  DATA_W  instruction SRAM address (byte address)
- imem_ren  out  1  instruction SRAM read enable
- imem_rdata  in  INSTR_W  SRAM data, valid the cycle after imem_ren
- out_valid  out  1  head entry valid toward decode
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  DATA_W  PC of head instruction
- out_instr  out  INSTR_W  head instruction

Behaviour:
- Reset (async, arst=1):
  - fetch_pc=RESET_PC, count=0, inflight=0, state=IDLE.
  - out_valid=0, imem_ren=0, imem_addr=RESET_PC.
  - out_pc/out_instr=0.
- FSM states:
  - IDLE:
    - No requests issued.
    - enable=1 goes to RUN.
    - redirect_valid in IDLE loads fetch_pc, stays IDLE.
  - RUN:
    - imem_ren=1 iff count+inflight < DEPTH (credit check, counting a same-cycle pop as freeing a slot).
    - imem_addr=fetch_pc; fetch_pc += 4 on each issue.
    - enable=0 goes to IDLE (an in-flight response is still captured).
    - redirect_valid goes to REDIR.
  - REDIR (exactly 1 cycle):
    - The response arriving this cycle (from the old path) is discarded.
    - Issues a request at the new fetch_pc if credit allows, fetch_pc += 4.
    - Next state is RUN if enable=1, else IDLE.
- Redirect handling:
  - On redirect_valid: FIFO cleared (count=0, pointers reset) at the clock edge.
  - fetch_pc <= {redirect_pc[DATA_W-1:2], 2'b00}; low two bits are ignored.
  - Redirect wins over a simultaneous push. A simultaneous pop (out_valid & out_ready) still completes toward decode.
  - redirect_valid in REDIR restarts REDIR with the newer target.
- Response capture: inflight = registered imem_ren & ~redirect. When inflight=1 and not in REDIR, push {issued_pc, imem_rdata}.
- FIFO:
  - Push and pop in the same cycle are legal when full or empty-with-bypass; count unchanged.
  - Overflow cannot occur by construction; the assertion count<=DEPTH must hold.
- Latency: request to out_valid is 2 cycles (issue at N, rdata at N+1, head visible at N+2).
- out_valid=0 when count=0. out_pc/out_instr are don't-care when out_valid=0.
- PC arithmetic is modulo 2^DATA_W; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- enable low mid-stream: no new issue; pending response still pushed; decode may keep draining.

Optional Feature:
- FETCH_BYPASS_EN:
  - Defined: when count=0 and a valid response arrives, it is presented on out_* combinationally the same cycle. If out_ready=1 it is not written to the FIFO. Latency is 1 cycle.
  - Undefined: all responses pass through the FIFO. Latency is 2 cycles.

Decomposition:
- Shared package holds:
  - fetch state enum (IDLE, RUN, REDIR)
  - PC_STEP=4
  - INSTR_NOP=32'h0000_0013
- One sub-module, fetch_fifo: parameterised DEPTH x (DATA_W+INSTR_W), with push/pop/clear, count, full/empty.
- fetch_queue holds the FSM, credit logic and fetch_pc.

Test Plan:
- Reset then enable=1, out_ready=1, imem returns 0x00000013 at 0,4,8 -> out_pc sequence 0,4,8 one per cycle, first out_valid 2 cycles after enable (1 with FETCH_BYPASS_EN).
- out_ready=0 for 10 cycles -> exactly DEPTH=4 entries (PCs 0..12) buffered, imem_ren drops to 0, no 5th request. Release out_ready -> PCs 0,4,8,12,16 in order, none lost or duplicated.
- redirect_valid with redirect_pc=0x100 while 3 entries queued and 1 in flight -> FIFO empty next cycle, old response discarded, next out_pc=0x100 then 0x104.
- redirect_pc=0x203 -> fetch restarts at 0x200.
- Redirect coincident with out_valid & out_ready -> head accepted once; no old-path entry is ever presented afterward.
- arst asserted mid-stream with 2 entries queued -> out_valid=0 and imem_ren=0 immediately (asynchronously). After release, fetch restarts at RESET_PC.
- RESET_PC=0xFFFF_FFFF_FFFF_FFF8 -> PCs ...FFF8, ...FFFC, 0x0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP   = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding {pc, instr} fetch entries; clear resets pointers and count.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assert property (@(posedge clk) disable iff (arst) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns fetch PC, issues credit-limited SRAM reads, queues {pc, instr} toward decode.
// Optional FETCH_BYPASS_EN presents a response arriving into an empty queue on the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               enable,
  input  logic               redirect_valid,
  input  logic [DATA_W-1:0]  redirect_pc,
  output logic [DATA_W-1:0]  imem_addr,
  output logic               imem_ren,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int unsigned ENTRY_W = DATA_W + INSTR_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned CW      = CNT_W + 1;

  fetch_state_e       state;
  fetch_state_e       state_nxt;
  logic [DATA_W-1:0]  fetch_pc;
  logic [DATA_W-1:0]  issued_pc;
  logic               inflight;
  logic               issue;
  logic               credit;
  logic               resp_valid;
  logic               bypass;
  logic               pop_out;
  logic               fifo_pop;
  logic               push;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A response landing during REDIR belongs to the abandoned path.
  assign resp_valid = inflight & (state != REDIR);

`ifdef FETCH_BYPASS_EN
  assign bypass = empty & resp_valid;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ~empty | bypass;
  assign pop_out   = out_valid & out_ready;
  assign fifo_pop  = out_ready & ~empty;
  assign push      = resp_valid & ~redirect_valid & ~(bypass & out_ready);

  // A slot freed by this cycle's accept may be reused by this cycle's request.
  assign credit = (CW'(count) + CW'(inflight)) < (CW'(DEPTH) + CW'(pop_out));

  assign imem_ren  = issue;
  assign imem_addr = fetch_pc;

  assign out_pc    = !out_valid ? '0 : (bypass ? issued_pc  : head[ENTRY_W-1 -: DATA_W]);
  assign out_instr = !out_valid ? '0 : (bypass ? imem_rdata : head[INSTR_W-1:0]);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!redirect_valid && enable) state_nxt = RUN;
      end
      RUN: begin
        issue = enable & ~redirect_valid & credit;
        if (redirect_valid) state_nxt = REDIR;
        else if (!enable)   state_nxt = IDLE;
      end
      REDIR: begin
        issue = enable & ~redirect_valid & credit;
        if (redirect_valid) state_nxt = REDIR;
        else                state_nxt = enable ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Requests are never issued in a redirect cycle, so inflight already excludes redirects.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) issued_pc <= fetch_pc;
      if (redirect_valid) fetch_pc <= {redirect_pc[DATA_W-1:2], 2'b00};
      else if (issue)     fetch_pc <= fetch_pc + DATA_W'(PC_STEP);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .arst  (arst),
    .push  (push),
    .pop   (fifo_pop),
    .clear (redirect_valid),
    .wdata ({issued_pc, imem_rdata}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assert property (@(posedge clk) disable iff (arst) push |-> (!full || fifo_pop));

endmodule
